// File: rtl/exec_pkg.sv
// Shared definitions for the register-file execute stage: opcodes, FSM states, flag indices.
package exec_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam int unsigned FLAG_Z    = 0;
  localparam int unsigned FLAG_C    = 1;
  localparam int unsigned FLAG_V    = 2;
  localparam int unsigned NUM_FLAGS = 3;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMul,
    StWb
  } state_e;

endpackage

// File: rtl/rf_exec_unit_if.sv
// Request/result bundle between the sequencer/register file and the execute stage.
interface rf_exec_unit_if #(
  parameter int unsigned W = 32
) ();

  logic         start;
  logic [2:0]   op;
  logic [2:0]   addr_dest_in;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         busy;
  logic         WR;
  logic [2:0]   addr_dest;
  logic [W-1:0] data_out;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  modport master (
    output start, op, addr_dest_in, srcA, srcB,
    input  busy, WR, addr_dest, data_out, flag_z, flag_c, flag_v
  );

  modport slave (
    input  start, op, addr_dest_in, srcA, srcB,
    output busy, WR, addr_dest, data_out, flag_z, flag_c, flag_v
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle into a 2W-bit accumulator.
module mul_iter #(
  parameter int unsigned W = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] product_o
);

  localparam int unsigned CntW = $clog2(W);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           active_q, active_d;
  logic [W:0]     sum;
  logic           last;

  assign last = active_q && (cnt_q == CntW'(W - 1));

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    sum      = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    if (start_i) begin
      acc_d    = {{W{1'b0}}, b_i};
      mcand_d  = a_i;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d = {sum, acc_q[W-1:1]};
      if (last) begin
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // Final product is the value the accumulator takes on the last iteration edge.
  assign done_o    = last;
  assign product_o = acc_d;

endmodule

// File: rtl/rf_exec_unit.sv
// Multi-cycle execute stage: latches register-file operands on start, computes, and
// returns the result as a one-cycle write strobe with registered Z/C/V flags.
module rf_exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input logic            clk,
  input logic            reset,
  rf_exec_unit_if.slave  bus
);

  state_e               state_q;
  logic                 busy_q;
  logic                 wr_q;
  logic [2:0]           dest_q;
  logic [2:0]           addr_q;
  logic [W-1:0]         data_q;
  logic [NUM_FLAGS-1:0] flags_q;
  logic [2:0]           op_q;
  logic [W-1:0]         a_q;
  logic [W-1:0]         b_q;

  logic                 accept;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*W-1:0]       product;
  logic [W:0]           add_w;
  logic [W:0]           sub_w;
  logic [W-1:0]         alu_res;
  logic [NUM_FLAGS-1:0] alu_flags;
  logic [NUM_FLAGS-1:0] mul_flags;

  assign accept    = (state_q == StIdle) && bus.start;
  assign mul_start = accept && (bus.op == OP_MUL);

  mul_iter #(
    .W (W)
  ) u_mul (
    .clk_i     (clk),
    .rst_i     (reset),
    .start_i   (mul_start),
    .a_i       (bus.srcA),
    .b_i       (bus.srcB),
    .done_o    (mul_done),
    .product_o (product)
  );

  always_comb begin
    add_w     = {1'b0, a_q} + {1'b0, b_q};
    sub_w     = {1'b0, a_q} - {1'b0, b_q};
    alu_res   = '0;
    alu_flags = '0;
    unique case (op_q)
      OP_ADD: begin
        alu_res           = add_w[W-1:0];
        alu_flags[FLAG_C] = add_w[W];
        alu_flags[FLAG_V] = (a_q[W-1] == b_q[W-1]) && (add_w[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        alu_res           = sub_w[W-1:0];
        alu_flags[FLAG_C] = sub_w[W];  // borrow: a < b unsigned
        alu_flags[FLAG_V] = (a_q[W-1] != b_q[W-1]) && (sub_w[W-1] != a_q[W-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: alu_res = a_q << b_q[4:0];
      OP_SHR: alu_res = a_q >> b_q[4:0];
      OP_MUL: alu_res = '0;
      default: alu_res = '0;
    endcase
    alu_flags[FLAG_Z] = (alu_res == '0);
  end

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (product[W-1:0] == '0);
    mul_flags[FLAG_C] = (product[2*W-1:W] != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      dest_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      flags_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      wr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            a_q     <= bus.srcA;
            b_q     <= bus.srcB;
            op_q    <= bus.op;
            dest_q  <= bus.addr_dest_in;
            busy_q  <= 1'b1;
            state_q <= (bus.op == OP_MUL) ? StMul : StExec;
          end
        end
        StExec: begin
          data_q  <= alu_res;
          flags_q <= alu_flags;
          addr_q  <= dest_q;
          wr_q    <= 1'b1;
          state_q <= StWb;
        end
        StMul: begin
          if (mul_done) begin
            data_q  <= product[W-1:0];
            flags_q <= mul_flags;
            addr_q  <= dest_q;
            wr_q    <= 1'b1;
            state_q <= StWb;
          end
        end
        StWb: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.WR        = wr_q;
  assign bus.addr_dest = addr_q;
  assign bus.data_out  = data_q;
  assign bus.flag_z    = flags_q[FLAG_Z];
  assign bus.flag_c    = flags_q[FLAG_C];
  assign bus.flag_v    = flags_q[FLAG_V];

endmodule

// File: doc/rf_exec_unit.md
# rf_exec_unit

Multi-cycle execute stage sitting directly downstream of the 8-entry register file. Samples the two register-file read ports (srcA, srcB) on a start strobe, performs one of eight ALU operations (multiply is iterative), and returns the result to the register file as a one-cycle write strobe with the latched destination address. Also produces registered zero, carry and overflow flags for the sequencer.

## Interface
- W, 32, datapath word length; must match the register file's W
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  3  opcode, sampled with start
- addr_dest_in  in  3  destination register index, sampled with start
- srcA  in  W  operand A, from register-file read port A
- srcB  in  W  operand B, from register-file read port B
- busy  out  1  high in every state except IDLE
- WR  out  1  one-cycle write strobe to the register file
- addr_dest  out  3  latched destination index; drives the register file's write address
- data_out  out  W  result; drives the register file's data_in
- flag_z, flag_c, flag_v  out  1 each  registered zero, carry/borrow, signed overflow

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL.
- Shift amount is srcB[4:0]; upper srcB bits ignored.
- FSM states: IDLE, EXEC, MUL, WB.
  - IDLE: on start, latch srcA, srcB, op and addr_dest_in. Go to MUL if op=7, else EXEC.
  - EXEC: compute the result and flags into registers. Go to WB.
  - MUL: shift-add over the full W-bit multiplier into a 2W-bit accumulator, one bit per cycle, with a 5-bit counter running 0..W-1. At count W-1, go to WB.
  - WB: WR=1, data_out and flags valid, addr_dest stable. Go to IDLE.
- Flags, updated only on entry to WB; otherwise they hold:
  - flag_z = (result==0).
  - ADD: flag_c = carry out of bit W-1.
  - SUB: flag_c = borrow, i.e. srcA<srcB unsigned.
  - ADD/SUB: flag_v = signed overflow.
  - MUL: flag_c = (product[2W-1:W] != 0); result = product[W-1:0]; flag_v = 0.
  - Logic and shift ops: flag_c = 0, flag_v = 0.
- start while busy=1 is ignored; no queuing.
- op, addr_dest_in and srcA/B are don't-care when start is not accepted.
- Reset, including reset during EXEC, MUL or WB:
  - next state IDLE;
  - busy=0, WR=0, addr_dest=0, data_out=0, all flags 0, counter and accumulator 0;
  - no write strobe is issued for the aborted operation.

## Timing
- Start accepted at edge T. Latencies:
  - non-MUL: WR high in cycle T+2;
  - MUL: WR high in cycle T+W+1, i.e. T+33 for W=32.
- busy rises in the cycle after acceptance and falls in the cycle after WB.
- A new start is therefore accepted at the earliest in the cycle after WB.
- The register-file write lands on the same edge that ends WB. A back-to-back op that reads the just-written register sees the new value, because srcA/srcB are sampled in IDLE, one cycle later.
- data_out, addr_dest and the flags hold their values after WB until the next WB or reset.

## Structure
- Shared package exec_pkg: opcode localparams (OP_ADD..OP_MUL), FSM state encoding, flag index constants.
- One sub-module, mul_iter: start/done shift-add multiplier holding the 2W-bit accumulator and the counter.
- The FSM and single-cycle ALU stay in rf_exec_unit.

## Test plan
- ADD, srcA=0xFFFFFFFF, srcB=1, addr_dest_in=5, start at T -> WR=1 only in cycle T+2, data_out=0, addr_dest=5, Z=1, C=1, V=0.
- SUB, srcA=0x80000000, srcB=1 -> data_out=0x7FFFFFFF, Z=0, C=0, V=1. SUB 3-5 -> 0xFFFFFFFE, C=1.
- MUL, srcA=0x00010000, srcB=0x00010000 -> WR at T+33, data_out=0, Z=1, C=1. MUL 7*6 -> 42, C=0.
- SHL, srcA=1, srcB=33 -> data_out=2 (shift uses srcB[4:0]=1). SHR, srcA=0x80000000, srcB=31 -> 1.
- Start pulsed every cycle during an in-flight MUL -> exactly one WR, at T+33; next accepted start is the one in the cycle after WB.
- Reset asserted 10 cycles into MUL -> next cycle busy=0, outputs and flags 0, no WR ever issued. A fresh ADD 2+3 then writes 5 at T+2.
